// File: rtl/factor_resonator.sv
// factor_resonator: multi-factor resonator controller. Each sweep unbinds the
// scene against every other estimate (XOR), sends the result to a shared
// clean-up unit, and writes the cleaned vector back as that factor's new
// estimate. Sweeps repeat until a sweep changes nothing or the cap is reached.
//
// Clean-up handshake: a transfer happens in every cycle where cu_req_out and
// cu_ack_in are both high. While cu_req_out is high and cu_ack_in is low,
// cu_factor_out and cu_vec_out are held unchanged. cu_result_in is only
// looked at in a transfer cycle.
module factor_resonator #(
  parameter int VECTOR_LEN  = 32,
  parameter int NUM_FACTORS = 3,
  parameter int MAX_ITERS   = 15,
  parameter int JACOBI      = 0,
  parameter int ITER_W      = $clog2(MAX_ITERS + 1),
  parameter int FACTOR_W    = (NUM_FACTORS > 1) ? $clog2(NUM_FACTORS) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_rstn,
  input  logic                              start_in,
  input  logic [VECTOR_LEN-1:0]             s_in,
  input  logic [NUM_FACTORS*VECTOR_LEN-1:0] init_in,
  output logic                              cu_req_out,
  output logic [FACTOR_W-1:0]               cu_factor_out,
  output logic [VECTOR_LEN-1:0]             cu_vec_out,
  input  logic                              cu_ack_in,
  input  logic [VECTOR_LEN-1:0]             cu_result_in,
  output logic                              busy_out,
  output logic                              done_out,
  output logic                              converged_out,
  output logic                              timeout_out,
  output logic [ITER_W-1:0]                 iter_count_out,
  output logic [NUM_FACTORS*VECTOR_LEN-1:0] x_hat_out,
  output logic [1:0]                        dbg_state_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [FACTOR_W-1:0] K_LAST    = FACTOR_W'(NUM_FACTORS - 1);
  localparam logic [ITER_W-1:0]   ITER_LAST = ITER_W'(MAX_ITERS - 1);

  state_t                            state;
  state_t                            state_nx;
  logic [FACTOR_W-1:0]               k;
  logic [ITER_W-1:0]                 iter;
  logic                              changed;
  logic                              converged;
  logic                              timeout;
  logic [VECTOR_LEN-1:0]             scene;
  logic [NUM_FACTORS*VECTOR_LEN-1:0] est;
  logic [NUM_FACTORS*VECTOR_LEN-1:0] snap;
  logic [NUM_FACTORS*VECTOR_LEN-1:0] src;
  logic [VECTOR_LEN-1:0]             unbound;
  logic [VECTOR_LEN-1:0]             cur_est;
  logic                              xfer;

  // Unbind the scene against every estimate except factor k; Jacobi mode
  // reads the sweep-start snapshot, Gauss-Seidel reads the live estimates.
  always_comb begin
    src     = (JACOBI != 0) ? snap : est;
    unbound = scene;
    cur_est = '0;
    for (int j = 0; j < NUM_FACTORS; j++) begin
      if (j != int'(k)) begin
        unbound = unbound ^ src[j*VECTOR_LEN +: VECTOR_LEN];
      end else begin
        cur_est = est[j*VECTOR_LEN +: VECTOR_LEN];
      end
    end
  end

  assign xfer = (state == S_REQ) && cu_ack_in;

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nx      = state;
    cu_req_out    = 1'b0;
    cu_factor_out = '0;
    cu_vec_out    = '0;
    busy_out      = 1'b1;
    done_out      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy_out = 1'b0;
        if (start_in) state_nx = S_REQ;
      end
      S_REQ: begin
        cu_req_out    = 1'b1;
        cu_factor_out = k;
        cu_vec_out    = unbound;
        if (cu_ack_in && (k == K_LAST)) state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (!changed || (iter == ITER_LAST)) state_nx = S_DONE;
        else                                 state_nx = S_REQ;
      end
      S_DONE: begin
        done_out = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: load on start, write back on each transfer, close out sweeps.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      k         <= '0;
      iter      <= '0;
      changed   <= 1'b0;
      converged <= 1'b0;
      timeout   <= 1'b0;
      scene     <= '0;
      est       <= '0;
      snap      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_in) begin
            scene     <= s_in;
            est       <= init_in;
            snap      <= init_in;
            k         <= '0;
            iter      <= '0;
            changed   <= 1'b0;
            converged <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        S_REQ: begin
          if (xfer) begin
            for (int j = 0; j < NUM_FACTORS; j++) begin
              if (j == int'(k)) est[j*VECTOR_LEN +: VECTOR_LEN] <= cu_result_in;
            end
            if (cu_result_in != cur_est) changed <= 1'b1;
            if (k != K_LAST) k <= k + FACTOR_W'(1);
          end
        end
        S_CHECK: begin
          iter <= iter + ITER_W'(1);
          k    <= '0;
          if (!changed) begin
            converged <= 1'b1;
          end else if (iter == ITER_LAST) begin
            timeout <= 1'b1;
          end else begin
            changed <= 1'b0;
            snap    <= est;
          end
        end
        default: ;
      endcase
    end
  end

  assign converged_out  = converged;
  assign timeout_out    = timeout;
  assign iter_count_out = iter;
  assign x_hat_out      = est;
  assign dbg_state_out  = state;

endmodule

// File: tb/tb_factor_resonator.sv
// Bench for factor_resonator: three instances (Gauss-Seidel cap 15, Jacobi
// cap 4, Gauss-Seidel cap 3) with VECTOR_LEN=8 and NUM_FACTORS=2, a clean-up
// responder, an algorithm-level model and one compare process.
module tb_factor_resonator;
  localparam int VL = 8;
  localparam int NF = 2;
  localparam int XW = NF * VL;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [2:0]    start_v = '0;
  logic [2:0]    ack_v   = '0;
  logic [VL-1:0] s_in    = '0;
  logic [XW-1:0] init_in = '0;
  logic [VL-1:0] res_in  = '0;
  logic [2:0]    req_v, busy_v, done_v, conv_v, tout_v;
  logic [0:0]    fac_a, fac_b, fac_c;
  logic [VL-1:0] vec_a, vec_b, vec_c;
  logic [XW-1:0] x_a, x_b, x_c;
  logic [3:0]    iter_a;
  logic [2:0]    iter_b;
  logic [1:0]    iter_c;
  logic [1:0]    st_a, st_b, st_c;

  factor_resonator #(.VECTOR_LEN(VL), .NUM_FACTORS(NF), .MAX_ITERS(15), .JACOBI(0)) dut_a (
    .i_clk(clk), .i_rstn(rst_n), .start_in(start_v[0]), .s_in(s_in), .init_in(init_in),
    .cu_req_out(req_v[0]), .cu_factor_out(fac_a), .cu_vec_out(vec_a),
    .cu_ack_in(ack_v[0]), .cu_result_in(res_in),
    .busy_out(busy_v[0]), .done_out(done_v[0]), .converged_out(conv_v[0]), .timeout_out(tout_v[0]),
    .iter_count_out(iter_a), .x_hat_out(x_a), .dbg_state_out(st_a));

  factor_resonator #(.VECTOR_LEN(VL), .NUM_FACTORS(NF), .MAX_ITERS(4), .JACOBI(1)) dut_b (
    .i_clk(clk), .i_rstn(rst_n), .start_in(start_v[1]), .s_in(s_in), .init_in(init_in),
    .cu_req_out(req_v[1]), .cu_factor_out(fac_b), .cu_vec_out(vec_b),
    .cu_ack_in(ack_v[1]), .cu_result_in(res_in),
    .busy_out(busy_v[1]), .done_out(done_v[1]), .converged_out(conv_v[1]), .timeout_out(tout_v[1]),
    .iter_count_out(iter_b), .x_hat_out(x_b), .dbg_state_out(st_b));

  factor_resonator #(.VECTOR_LEN(VL), .NUM_FACTORS(NF), .MAX_ITERS(3), .JACOBI(0)) dut_c (
    .i_clk(clk), .i_rstn(rst_n), .start_in(start_v[2]), .s_in(s_in), .init_in(init_in),
    .cu_req_out(req_v[2]), .cu_factor_out(fac_c), .cu_vec_out(vec_c),
    .cu_ack_in(ack_v[2]), .cu_result_in(res_in),
    .busy_out(busy_v[2]), .done_out(done_v[2]), .converged_out(conv_v[2]), .timeout_out(tout_v[2]),
    .iter_count_out(iter_c), .x_hat_out(x_c), .dbg_state_out(st_c));

  // ---------------- view of the selected instance ----------------
  int            sel = 0;
  logic          m_req, m_busy, m_done, m_conv, m_tout;
  logic [0:0]    m_fac;
  logic [VL-1:0] m_vec;
  logic [XW-1:0] m_x;
  logic [31:0]   m_iter;
  logic [1:0]    m_st;

  always_comb begin
    m_req  = req_v[0];  m_busy = busy_v[0]; m_done = done_v[0];
    m_conv = conv_v[0]; m_tout = tout_v[0]; m_fac  = fac_a;
    m_vec  = vec_a;     m_x    = x_a;       m_iter = 32'(iter_a); m_st = st_a;
    case (sel)
      1: begin
        m_req  = req_v[1];  m_busy = busy_v[1]; m_done = done_v[1];
        m_conv = conv_v[1]; m_tout = tout_v[1]; m_fac  = fac_b;
        m_vec  = vec_b;     m_x    = x_b;       m_iter = 32'(iter_b); m_st = st_b;
      end
      2: begin
        m_req  = req_v[2];  m_busy = busy_v[2]; m_done = done_v[2];
        m_conv = conv_v[2]; m_tout = tout_v[2]; m_fac  = fac_c;
        m_vec  = vec_c;     m_x    = x_c;       m_iter = 32'(iter_c); m_st = st_c;
      end
      default: ;
    endcase
  end

  // ---------------- counters and check helper ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- clean-up responder (driver) ----------------
  // mode 0: identity clean-up; mode 1: returns 1,2,3,... per transfer.
  // wait_mode: acknowledge each request on its third cycle.
  int   mode      = 0;
  bit   wait_mode = 1'b0;
  int   wcnt      = 0;
  int   inc_cnt   = 1;
  logic ack_now   = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      ack_now = 1'b0;
      if (m_req) begin
        if (!wait_mode || wcnt == 2) begin
          ack_now = 1'b1;
          wcnt    = 0;
          res_in  = (mode == 1) ? inc_cnt[VL-1:0] : m_vec;
          if (mode == 1) inc_cnt++;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      ack_v      = '0;
      ack_v[sel] = ack_now;
    end
  end

  // ---------------- algorithm-level model ----------------
  logic [VL:0]   exp_q[$];   // {factor, unbound vector} per expected transfer
  logic [XW-1:0] exp_x;
  int            exp_sweeps;
  int            exp_xfers;
  int            exp_lat;
  bit            exp_conv;
  bit            exp_tout;

  function automatic void model_run(input int jac, input int maxit, input int md,
                                    input logic [VL-1:0] s, input logic [XW-1:0] init);
    logic [VL-1:0] est  [NF];
    logic [VL-1:0] snap [NF];
    logic [VL-1:0] v;
    logic [VL-1:0] r;
    int            cnt;
    bit            ch;
    cnt = 1;
    exp_q.delete();
    exp_sweeps = 0;
    exp_conv   = 1'b0;
    for (int j = 0; j < NF; j++) est[j] = init[j*VL +: VL];
    for (int sw = 0; sw < maxit && !exp_conv; sw++) begin
      snap = est;
      ch   = 1'b0;
      for (int f = 0; f < NF; f++) begin
        v = s;
        for (int j = 0; j < NF; j++) if (j != f) v ^= (jac != 0) ? snap[j] : est[j];
        exp_q.push_back({f[0], v});
        r = (md == 1) ? cnt[VL-1:0] : v;
        cnt++;
        if (r != est[f]) ch = 1'b1;
        est[f] = r;
      end
      exp_sweeps++;
      if (!ch) exp_conv = 1'b1;
    end
    exp_tout  = !exp_conv;
    exp_xfers = exp_sweeps * NF;
    for (int j = 0; j < NF; j++) exp_x[j*VL +: VL] = est[j];
  endfunction

  // ---------------- compare process (scoreboard) ----------------
  int         t0        = 0;
  bit         prev_wait = 1'b0;
  bit         prev_done = 1'b0;
  logic [VL:0] held     = '0;
  int         done_cnt  = 0;
  int         done_cyc  = 0;
  int         ack_cnt   = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wait = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (m_req) begin
        if (prev_wait) chk("hold_req", 32'({m_fac, m_vec}), 32'(held));
        if (ack_now) begin
          ack_cnt++;
          chk("req_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) chk("req_vec", 32'({m_fac, m_vec}), 32'(exp_q.pop_front()));
          prev_wait = 1'b0;
        end else begin
          held      = {m_fac, m_vec};
          prev_wait = 1'b1;
        end
      end else begin
        prev_wait = 1'b0;
      end
      if (m_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_width",  32'(prev_done), 32'd0);
        chk("done_lat",    32'(cyc - t0), 32'(exp_lat));
        chk("fin_x",       32'(m_x), 32'(exp_x));
        chk("fin_iter",    m_iter, 32'(exp_sweeps));
        chk("fin_conv",    32'(m_conv), 32'(exp_conv));
        chk("fin_tout",    32'(m_tout), 32'(exp_tout));
        chk("fin_exclus",  32'(m_conv & m_tout), 32'd0);
        chk("fin_q_empty", 32'(exp_q.size()), 32'd0);
      end
      prev_done = m_done;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic launch(input int which, input int jac, input int maxit, input int md,
                        input bit wm, input logic [VL-1:0] s, input logic [XW-1:0] init);
    sel       = which;
    mode      = md;
    wait_mode = wm;
    inc_cnt   = 1;
    model_run(jac, maxit, md, s, init);
    exp_lat = exp_sweeps * (NF + 1) + (wm ? 2 * exp_xfers : 0);
    s_in    = s;
    init_in = init;
    start_v        = '0;
    start_v[which] = 1'b1;
    @(posedge clk);
    #1;
    start_v = '0;
    t0      = cyc;
  endtask

  // Returns at posedge+1 of the cycle after the done pulse.
  task automatic wait_done(input string name, input int budget);
    int c0;
    c0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == c0; i++) @(posedge clk);
    #1;
    chk(name, 32'(done_cnt - c0), 32'd1);
  endtask

  task automatic expect_final(input string tag, input logic [XW-1:0] x, input int it,
                              input bit cv, input bit to, input int lat);
    chk({tag, "_x"},    32'(m_x), 32'(x));
    chk({tag, "_iter"}, m_iter, 32'(it));
    chk({tag, "_conv"}, 32'(m_conv), 32'(cv));
    chk({tag, "_tout"}, 32'(m_tout), 32'(to));
    chk({tag, "_busy"}, 32'(m_busy), 32'd0);
    chk({tag, "_lat"},  32'(done_cyc - t0), 32'(lat));
  endtask

  task automatic expect_all_zero(input string tag);
    chk({tag, "_req"},  32'(m_req), 32'd0);
    chk({tag, "_fac"},  32'(m_fac), 32'd0);
    chk({tag, "_vec"},  32'(m_vec), 32'd0);
    chk({tag, "_busy"}, 32'(m_busy), 32'd0);
    chk({tag, "_done"}, 32'(m_done), 32'd0);
    chk({tag, "_conv"}, 32'(m_conv), 32'd0);
    chk({tag, "_tout"}, 32'(m_tout), 32'd0);
    chk({tag, "_iter"}, m_iter, 32'd0);
    chk({tag, "_x"},    32'(m_x), 32'd0);
    chk({tag, "_st"},   32'(m_st), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int a0;
  int d0;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_all_zero("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: identity clean-up, Gauss-Seidel -> converges after 2 sweeps.
    launch(0, 0, 15, 0, 1'b0, 8'hA5, 16'h000F);
    wait_done("t1_done", 40);
    expect_final("t1", 16'h00A5, 2, 1'b1, 1'b0, 6);

    // 2: same stimulus, Jacobi, cap 4 -> oscillates and times out.
    launch(1, 1, 4, 0, 1'b0, 8'hA5, 16'h000F);
    wait_done("t2_done", 60);
    expect_final("t2", 16'h000F, 4, 1'b0, 1'b1, 12);

    // 3: incrementing clean-up, cap 3 -> six transfers, timeout.
    a0 = ack_cnt;
    launch(2, 0, 3, 1, 1'b0, 8'hA5, 16'h000F);
    wait_done("t3_done", 60);
    expect_final("t3", 16'h0605, 3, 1'b0, 1'b1, 9);
    chk("t3_xfers", 32'(ack_cnt - a0), 32'd6);

    // 4: test 1 with acknowledge on every third cycle -> 8 cycles later.
    launch(0, 0, 15, 0, 1'b1, 8'hA5, 16'h000F);
    wait_done("t4_done", 60);
    expect_final("t4", 16'h00A5, 2, 1'b1, 1'b0, 14);

    // 5a: start pulses with different data while busy are ignored.
    launch(0, 0, 15, 0, 1'b0, 8'hA5, 16'h000F);
    @(posedge clk);
    #1;
    s_in       = 8'hFF;
    init_in    = 16'hFFFF;
    start_v[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start_v = '0;
    wait_done("t5a_done", 40);
    expect_final("t5a", 16'h00A5, 2, 1'b1, 1'b0, 6);

    // 5b: reset three cycles into a run aborts with no done pulse.
    launch(0, 0, 15, 0, 1'b0, 8'hA5, 16'h000F);
    repeat (3) @(posedge clk);
    #1;
    d0    = done_cnt;
    rst_n = 1'b0;
    #1;
    expect_all_zero("abort");
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    launch(0, 0, 15, 0, 1'b0, 8'hA5, 16'h000F);
    wait_done("t5b_done", 40);
    expect_final("t5b", 16'h00A5, 2, 1'b1, 1'b0, 6);

    // 6: back-to-back runs, second start right after the done cycle.
    launch(0, 0, 15, 1, 1'b0, 8'hA5, 16'h000F);
    wait_done("t6a_done", 120);
    expect_final("t6a", 16'h1E1D, 15, 1'b0, 1'b1, 45);
    launch(0, 0, 15, 0, 1'b0, 8'h3C, 16'h003C);
    chk("t6_tout_clr", 32'(m_tout), 32'd0);
    chk("t6_conv_clr", 32'(m_conv), 32'd0);
    chk("t6_iter_clr", m_iter, 32'd0);
    wait_done("t6b_done", 40);
    expect_final("t6b", 16'h003C, 1, 1'b1, 1'b0, 3);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
